// File: rtl/i2c_master_arbiter.sv
// Round-robin arbiter sharing one i2c_controller master between NREQ clients.
// Ports: req/req_addr/req_data/req_rw in, gnt/done/err/rd_data out, m_* to master.
module i2c_master_arbiter #(
  parameter int NREQ    = 4,
  parameter int TIMEOUT = 4096,
  parameter int CW      = 13
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NREQ-1:0]   req,
  input  logic [7*NREQ-1:0] req_addr,
  input  logic [8*NREQ-1:0] req_data,
  input  logic [NREQ-1:0]   req_rw,
  output logic [NREQ-1:0]   gnt,
  output logic [NREQ-1:0]   done,
  output logic              err,
  output logic [7:0]        rd_data,
  output logic [6:0]        m_addr,
  output logic [7:0]        m_data_in,
  output logic              m_rw,
  output logic              m_enable,
  input  logic [7:0]        m_data_out,
  input  logic              m_ready
);

  localparam int IW = $clog2(NREQ);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_BUSY,
    S_DONE
  } state_t;

  state_t          r_state;
  logic [IW-1:0]   r_rr;
  logic [IW-1:0]   r_own;
  logic [CW-1:0]   r_tmr;
  logic [NREQ-1:0] r_gnt;
  logic [NREQ-1:0] r_done;
  logic            r_err;
  logic [7:0]      r_rd;
  logic [6:0]      r_addr;
  logic [7:0]      r_wdat;
  logic            r_rw;
  logic            r_en;

  logic            w_any;
  logic [IW-1:0]   w_idx;
  logic [IW:0]     w_j;
  logic            w_tmo;
  logic [IW-1:0]   w_rr_nxt;

  // First set request at or above the rotation pointer, wrapping.
  always_comb begin
    w_any = 1'b0;
    w_idx = '0;
    w_j   = '0;
    for (int k = 0; k < NREQ; k++) begin
      w_j = {1'b0, r_rr} + (IW+1)'(k);
      if (w_j >= (IW+1)'(NREQ))
        w_j = w_j - (IW+1)'(NREQ);
      if (!w_any && req[w_j[IW-1:0]]) begin
        w_any = 1'b1;
        w_idx = w_j[IW-1:0];
      end
    end
  end

  assign w_tmo    = (r_tmr == CW'(TIMEOUT - 1));
  assign w_rr_nxt = (r_own == IW'(NREQ - 1)) ? '0 : r_own + 1'b1;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= S_IDLE;
      r_rr    <= '0;
      r_own   <= '0;
      r_tmr   <= '0;
      r_gnt   <= '0;
      r_done  <= '0;
      r_err   <= 1'b0;
      r_rd    <= '0;
      r_addr  <= '0;
      r_wdat  <= '0;
      r_rw    <= 1'b0;
      r_en    <= 1'b0;
    end else begin
      r_done <= '0;
      r_err  <= 1'b0;
      unique case (r_state)
        S_IDLE: begin
          if (w_any && m_ready) begin
            r_own   <= w_idx;
            r_gnt   <= NREQ'(1) << w_idx;
            r_addr  <= req_addr[7*w_idx +: 7];
            r_wdat  <= req_data[8*w_idx +: 8];
            r_rw    <= req_rw[w_idx];
            r_en    <= 1'b1;
            r_tmr   <= '0;
            r_state <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          if (!m_ready) begin
            r_en    <= 1'b0;
            r_tmr   <= '0;
            r_state <= S_BUSY;
          end else if (w_tmo) begin
            r_en    <= 1'b0;
            r_done  <= r_gnt;
            r_err   <= 1'b1;
            r_state <= S_DONE;
          end else begin
            r_tmr <= r_tmr + 1'b1;
          end
        end
        S_BUSY: begin
          if (m_ready) begin
            r_done  <= r_gnt;
            if (r_rw)
              r_rd <= m_data_out;
            r_state <= S_DONE;
          end else if (w_tmo) begin
            r_done  <= r_gnt;
            r_err   <= 1'b1;
            r_state <= S_DONE;
          end else begin
            r_tmr <= r_tmr + 1'b1;
          end
        end
        S_DONE: begin
          r_gnt   <= '0;
          r_rr    <= w_rr_nxt;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign gnt       = r_gnt;
  assign done      = r_done;
  assign err       = r_err;
  assign rd_data   = r_rd;
  assign m_addr    = r_addr;
  assign m_data_in = r_wdat;
  assign m_rw      = r_rw;
  assign m_enable  = r_en;

endmodule

// File: doc/i2c_master_arbiter.md
Name: i2c_master_arbiter

Overview:
- Shares one i2c_controller master between NREQ independent requesters using round-robin arbitration.
- Latches the granted requester's address, write data and rw, then drives the master's enable/ready handshake.
- Returns a one-cycle done pulse, plus read data for read transactions, to the owner.
- Sits between system-side clients (sensor pollers, config loaders) and the i2c_controller.

Parameters:
- NREQ, 4, number of requesters, legal range 2..8.
- TIMEOUT, 4096, cycles allowed in each of ISSUE and BUSY before the transaction is aborted with err.
- CW, 13, timeout counter width; must satisfy 2^CW > TIMEOUT.

Ports:
- clk  input  1  system clock; all state on rising edge.
- rst  input  1  asynchronous, active-low reset (rst=0 resets).
- req  input  NREQ  per-requester request level; held until that requester's done.
- req_addr  input  7*NREQ  7-bit slave address per requester; requester i uses bits [7i+6:7i].
- req_data  input  8*NREQ  write byte per requester; requester i uses bits [8i+7:8i].
- req_rw  input  NREQ  per-requester direction: 1=read, 0=write.
- gnt  output  NREQ  one-hot; the current owner's bit is high from grant until done.
- done  output  NREQ  one-cycle pulse to the owner when its transaction ends.
- err  output  1  one-cycle pulse coincident with done on a timeout.
- rd_data  output  8  read byte of the last successful read; holds between reads.
- m_addr  output  7  to i2c_controller addr.
- m_data_in  output  8  to i2c_controller data_in.
- m_rw  output  1  to i2c_controller rw.
- m_enable  output  1  to i2c_controller enable.
- m_data_out  input  8  from i2c_controller data_out.
- m_ready  input  1  from i2c_controller ready; 1 = master idle.

Behaviour:
- Reset (rst=0, asynchronous)
  - state=IDLE, rr pointer=0.
  - gnt, done, err, m_enable, m_rw = 0; m_addr, m_data_in, rd_data = 0.
  - Effective immediately, including mid-transaction. No done is produced for an aborted owner.
- States: IDLE, ISSUE, BUSY, DONE. All outputs are registered.
- IDLE
  - If any req bit is set and m_ready=1, pick the first set bit searching upward from rr pointer, wrapping modulo NREQ.
  - Next cycle: gnt one-hot; m_addr/m_data_in/m_rw latched from that slice; m_enable=1; timer cleared; state=ISSUE.
  - If m_ready=0, no grant is issued.
  - Latency: req seen to m_enable high = 1 cycle.
- ISSUE
  - m_enable is held at 1 until m_ready is sampled 0 (master accepted), then m_enable=0 and state=BUSY with timer cleared.
  - Latched fields are stable for the whole transaction, even if the requester changes its inputs.
- BUSY
  - Wait for m_ready=1, then go to DONE.
- DONE (one cycle)
  - done[owner]=1.
  - If m_rw=1, rd_data is captured from m_data_out on the same edge as done rises.
  - gnt cleared; rr pointer = owner+1 modulo NREQ; state=IDLE.
- Timeout
  - The timer increments every cycle in ISSUE and BUSY.
  - If it reaches TIMEOUT, the arbiter drives m_enable=0, pulses done[owner] and err together, does not update rd_data, advances the rr pointer, and returns to IDLE.
- Request dropped mid-transaction: the I2C transfer cannot be aborted, so the transaction completes normally and done is still pulsed.
- Request still high the cycle after done: the requester is eligible again, but rotation gives priority to others. A sole requester is re-granted after 1 idle cycle.
- Simultaneous requests: exactly one grant. The others wait with no loss.
- Back-to-back minimum: done to the next m_enable = 2 cycles (DONE, then IDLE arbitration).
- gnt is never multi-hot. done and err are never high outside a DONE cycle.

Test Plan:
- Reset then single write: req[0]=1, addr 7'h2A, data 8'hAA, rw=0; model master drops ready 3 cycles after enable and raises it 40 cycles later. Required: m_enable high 1 cycle after req for 3 cycles; m_addr=2A, m_data_in=AA; done[0] pulses once; rd_data stays 00; err=0.
- Read: req[2], addr 7'h51, rw=1; master returns data_out=8'h5C. Required: done[2] pulse with rd_data=5C on the same cycle.
- Round-robin: req=4'b1111 held continuously. Required: grant order 0,1,2,3,0; after reset-mid-sequence, order restarts at 0.
- Timeout: master never drops ready after enable, TIMEOUT=16. Required: done[1] and err high on the same cycle 16 cycles into ISSUE; m_enable=0; rd_data unchanged. Repeat with ready stuck low in BUSY and require the same response.
- Mid-operation events: requester drops req during BUSY, then the test asserts rst=0 during a later BUSY. Required: done still pulses in the first case; in the second, m_enable/gnt/done go 0 asynchronously within the reset cycle and no done is emitted after release.
